// File: rtl/score_keeper_pkg.sv
// -----------------------------------------------------------------------------
// score_keeper_pkg
// Shared constants, widths, FSM state encoding and the saturating score adder
// used by the score_keeper block and its seconds divider.
// -----------------------------------------------------------------------------
package score_keeper_pkg;

    localparam int SCORE_W = 24;
    localparam int TIME_W  = 12;
    localparam int SEC_W   = 6;

    localparam int                FRAMES_PER_SEC = 60;
    localparam logic [TIME_W-1:0] TIME_INIT      = 12'd300;

    localparam logic [SCORE_W-1:0] PICKUP_PTS    = 24'd100;
    localparam logic [SCORE_W-1:0] ENEMY_PTS     = 24'd50;
    localparam logic [SCORE_W-1:0] BONUS_PER_SEC = 24'd10;
    localparam logic [SCORE_W-1:0] SCORE_MAX     = 24'd999999;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        BONUS    = 2'd1,
        RELOAD   = 2'd2,
        EXPIRED  = 2'd3
    } state_e;

    // One extra bit of headroom so a carry past SCORE_MAX is seen before the
    // clamp, which keeps the score from ever wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                   input logic [SCORE_W-1:0] pts);
        logic [SCORE_W:0] sum;
        sum = {1'b0, base} + {1'b0, pts};
        return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// -----------------------------------------------------------------------------
// score_keeper_if
// Game-event inputs and score/timer outputs of score_keeper.
//   frame_tick, pickup_pulse, enemy_pulse, hero_rst : one-cycle event pulses
//   score, hi_score (24b), time_left (12b), bonus_busy, time_out : results
// master: the game logic driving events; slave: the score_keeper block.
// -----------------------------------------------------------------------------
interface score_keeper_if;
    import score_keeper_pkg::*;

    logic               frame_tick;
    logic               pickup_pulse;
    logic               enemy_pulse;
    logic               hero_rst;
    logic [SCORE_W-1:0] score;
    logic [TIME_W-1:0]  time_left;
    logic               bonus_busy;
    logic               time_out;
    logic [SCORE_W-1:0] hi_score;

    modport master (
        output frame_tick, pickup_pulse, enemy_pulse, hero_rst,
        input  score, time_left, bonus_busy, time_out, hi_score
    );

    modport slave (
        input  frame_tick, pickup_pulse, enemy_pulse, hero_rst,
        output score, time_left, bonus_busy, time_out, hi_score
    );

endinterface

// File: rtl/score_keeper_sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
// Divides frame ticks down to one pulse per second (every FRAMES_PER_SEC-th
// tick). Counter runs 0..FRAMES_PER_SEC-1 and wraps.
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : synchronous clear of the frame counter (wins over tick_en)
//   tick_en   : a frame tick that should be counted
//   sec_pulse : high in the cycle whose tick completes a second
// -----------------------------------------------------------------------------
module sec_tick_gen
    import score_keeper_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick_en,
    output logic sec_pulse
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(FRAMES_PER_SEC - 1);

    logic [SEC_W-1:0] cnt_q, cnt_d;

    assign sec_pulse = tick_en && !clr && (cnt_q == SEC_LAST);

    always_comb begin
        // NOTE: assign the default before any branch so no path leaves cnt_d
        // unassigned; otherwise synthesis infers a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick_en) begin
            cnt_d = (cnt_q == SEC_LAST) ? '0 : cnt_q + SEC_W'(1);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// Running score, level countdown timer and end-of-level time bonus transfer.
//   clk, rst : clock, asynchronous active-low reset
//   sk       : score_keeper_if.slave (event pulses in, score/timer out)
// FSM: PLAY (count down, score events) -> BONUS on hero_rst (time converted to
// points one second per frame) -> RELOAD (timer reload, one cycle) -> PLAY.
// PLAY -> EXPIRED when the timer runs out; EXPIRED -> RELOAD on hero_rst.
// Optional feature macro SCORE_KEEPER_HISCORE_EN: when defined, hi_score tracks
// the best score since reset; when undefined, hi_score is tied to 0.
// -----------------------------------------------------------------------------
module score_keeper
    import score_keeper_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    score_keeper_if.slave sk
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [TIME_W-1:0]  time_left_q, time_left_d;
    logic               bonus_busy_q, bonus_busy_d;
    logic               time_out_q, time_out_d;

    logic [SCORE_W-1:0] play_pts;
    logic               sec_en;
    logic               sec_clr;
    logic               sec_pulse;

    // Both events in one cycle simply add up (150).
    assign play_pts = (sk.pickup_pulse ? PICKUP_PTS : '0) +
                      (sk.enemy_pulse  ? ENEMY_PTS  : '0);

    // A hero_rst in PLAY pre-empts the tick, so the second does not advance.
    assign sec_en  = sk.frame_tick && !sk.hero_rst && (state_q == PLAY);
    assign sec_clr = (state_q == RELOAD);

    sec_tick_gen u_sec_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (sec_clr),
        .tick_en   (sec_en),
        .sec_pulse (sec_pulse)
    );

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        time_left_d = time_left_q;
        time_out_d  = 1'b0;

        unique case (state_q)
            PLAY: begin
                score_d = sat_add(score_q, play_pts);
                if (sk.hero_rst) begin
                    // Level-up beats an expiring timer: no time_out then.
                    state_d = BONUS;
                end else if (sec_pulse && (time_left_q != '0)) begin
                    time_left_d = time_left_q - TIME_W'(1);
                    if (time_left_q == TIME_W'(1)) begin
                        time_out_d = 1'b1;
                        state_d    = EXPIRED;
                    end
                end
            end
            EXPIRED: begin
                score_d     = sat_add(score_q, play_pts);
                time_left_d = '0;
                if (sk.hero_rst) begin
                    state_d = RELOAD;
                end
            end
            BONUS: begin
                // Score events and repeated hero_rst are ignored here.
                if (time_left_q == '0) begin
                    state_d = RELOAD;
                end else if (sk.frame_tick) begin
                    score_d     = sat_add(score_q, BONUS_PER_SEC);
                    time_left_d = time_left_q - TIME_W'(1);
                end
            end
            RELOAD: begin
                time_left_d = TIME_INIT;
                state_d     = PLAY;
            end
            default: begin
                state_d = PLAY;
            end
        endcase

        // Registered copy of "next state is BONUS": rises on the edge that
        // enters BONUS and falls on the edge that leaves it.
        bonus_busy_d = (state_d == BONUS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PLAY;
            score_q      <= '0;
            time_left_q  <= TIME_INIT;
            bonus_busy_q <= 1'b0;
            time_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            time_left_q  <= time_left_d;
            bonus_busy_q <= bonus_busy_d;
            time_out_q   <= time_out_d;
        end
    end

    assign sk.score      = score_q;
    assign sk.time_left  = time_left_q;
    assign sk.bonus_busy = bonus_busy_q;
    assign sk.time_out   = time_out_q;

`ifdef SCORE_KEEPER_HISCORE_EN
    logic [SCORE_W-1:0] hi_score_q, hi_score_d;

    // Follows the registered score, hence one cycle behind it.
    always_comb begin
        hi_score_d = (score_q > hi_score_q) ? score_q : hi_score_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_score_q <= '0;
        end else begin
            hi_score_q <= hi_score_d;
        end
    end

    assign sk.hi_score = hi_score_q;
`else
    assign sk.hi_score = '0;
`endif

endmodule
